// File: rtl/d8m_pattern_source_pkg.sv
// Shared types for the synthetic D8M raw-Bayer stream source:
// FSM states, Bayer site encoding and pattern select codes.
package d8m_pattern_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_VBLANK     = 2'd1,
        ST_ACTIVE_PIX = 2'd2,
        ST_ACTIVE_BLK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SITE_R = 2'd0,
        SITE_G = 2'd1,
        SITE_B = 2'd2
    } bayer_site_t;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_FLAT  = 2'd3;

    localparam logic [9:0] PIX_FULL = 10'h3FF;
    localparam logic [9:0] PIX_ZERO = 10'h000;

    // GRBG mosaic: even rows G/R, odd rows B/G.
    function automatic bayer_site_t bayer_site(input logic x_lsb, input logic y_lsb);
        bayer_site_t site;
        case ({y_lsb, x_lsb})
            2'b00:   site = SITE_G;
            2'b01:   site = SITE_R;
            2'b10:   site = SITE_B;
            2'b11:   site = SITE_G;
            default: site = SITE_G;
        endcase
        return site;
    endfunction

endpackage

// File: rtl/d8m_pattern_source_pixel.sv
// Combinational pixel generator: maps raster position, latched pattern,
// bar index and latched frame count to one 10-bit raw Bayer sample.
module d8m_pattern_pixel
    import d8m_pattern_source_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [1:0]  sel,
    input  logic [2:0]  bar,
    input  logic [7:0]  flat_cnt,
    output logic [9:0]  d
);

    bayer_site_t site_s;
    logic [2:0]  rgb_s;
    logic        chan_on_s;
    logic        unused_s;

    // Only the low ten x bits and y bits 0 and 5 shape any pattern.
    assign unused_s = ^{x[10], y[10:6], y[4:1]};

    // Colour-bar channel enable at the current Bayer site ({R,G,B} = ~bar).
    always_comb begin
        site_s    = bayer_site(x[0], y[0]);
        rgb_s     = ~bar;
        chan_on_s = 1'b0;
        case (site_s)
            SITE_R:  chan_on_s = rgb_s[2];
            SITE_G:  chan_on_s = rgb_s[1];
            SITE_B:  chan_on_s = rgb_s[0];
            default: chan_on_s = 1'b0;
        endcase
    end

    // Pattern multiplexer.
    always_comb begin
        d = PIX_ZERO;
        case (sel)
            PAT_RAMP:  d = x[9:0];
            PAT_BARS:  begin
                if (chan_on_s) d = PIX_FULL;
                else           d = PIX_ZERO;
            end
            PAT_CHECK: begin
                if (x[5] ^ y[5]) d = PIX_FULL;
                else             d = PIX_ZERO;
            end
            PAT_FLAT:  d = {flat_cnt, 2'b00};
            default:   d = PIX_ZERO;
        endcase
    end

endmodule

// File: rtl/d8m_pattern_source.sv
// Synthetic D8M camera transmitter: raster FSM, counters and registered
// MIPI_PIXEL_D/HS/VS outputs driven from the next-state raster position.
module d8m_pattern_source
    import d8m_pattern_source_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_BLANK  = 45,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BAR_W    = 80
) (
    input  logic       MIPI_PIXEL_CLK,
    input  logic       RESET_N,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic [9:0] MIPI_PIXEL_D,
    output logic       MIPI_PIXEL_HS,
    output logic       MIPI_PIXEL_VS,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam logic [10:0] LINE_LAST = 11'(H_ACTIVE + H_BLANK - 1);
    localparam logic [10:0] HACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] HBLK_LAST = 11'(H_BLANK - 1);
    localparam logic [10:0] VBLK_LAST = 11'(V_BLANK - 1);
    localparam logic [10:0] VACT_LAST = 11'(V_ACTIVE - 1);
    localparam logic [6:0]  BAR_LAST  = 7'(BAR_W - 1);

    state_t      state_r, state_nxt_s;
    logic [10:0] x_r, x_nxt_s;
    logic [10:0] y_r, y_nxt_s;
    logic [2:0]  bar_r, bar_nxt_s;
    logic [6:0]  bar_px_r, bar_px_nxt_s;
    logic [1:0]  sel_r, sel_nxt_s;
    logic [7:0]  fcnt_r, fcnt_nxt_s;
    logic [7:0]  flat_r, flat_nxt_s;
    logic        fs_nxt_s;
    logic        hs_nxt_s, vs_nxt_s;
    logic [9:0]  d_nxt_s, pix_s;
    logic [9:0]  d_r;
    logic        hs_r, vs_r, fs_r;

    // x doubles as the in-line cycle counter and y as the blank-line counter
    // during VBLANK, so one pair of counters covers the whole raster.
    always_comb begin
        state_nxt_s  = state_r;
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        bar_nxt_s    = bar_r;
        bar_px_nxt_s = bar_px_r;
        sel_nxt_s    = sel_r;
        fcnt_nxt_s   = fcnt_r;
        flat_nxt_s   = flat_r;
        fs_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                x_nxt_s      = 11'd0;
                y_nxt_s      = 11'd0;
                bar_nxt_s    = 3'd0;
                bar_px_nxt_s = 7'd0;
                if (enable) state_nxt_s = ST_VBLANK;
                else        state_nxt_s = ST_IDLE;
            end
            ST_VBLANK: begin
                if (x_r == LINE_LAST) begin
                    x_nxt_s = 11'd0;
                    if (y_r == VBLK_LAST) begin
                        y_nxt_s      = 11'd0;
                        bar_nxt_s    = 3'd0;
                        bar_px_nxt_s = 7'd0;
                        if (enable) begin
                            state_nxt_s = ST_ACTIVE_PIX;
                            sel_nxt_s   = pattern_sel;
                            flat_nxt_s  = fcnt_r;
                            fs_nxt_s    = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        y_nxt_s = y_r + 11'd1;
                    end
                end else begin
                    x_nxt_s = x_r + 11'd1;
                end
            end
            ST_ACTIVE_PIX: begin
                if (x_r == HACT_LAST) begin
                    x_nxt_s     = 11'd0;
                    state_nxt_s = ST_ACTIVE_BLK;
                end else begin
                    x_nxt_s = x_r + 11'd1;
                    if (bar_px_r == BAR_LAST) begin
                        bar_px_nxt_s = 7'd0;
                        bar_nxt_s    = bar_r + 3'd1;
                    end else begin
                        bar_px_nxt_s = bar_px_r + 7'd1;
                    end
                end
            end
            ST_ACTIVE_BLK: begin
                if (x_r == HBLK_LAST) begin
                    x_nxt_s      = 11'd0;
                    bar_nxt_s    = 3'd0;
                    bar_px_nxt_s = 7'd0;
                    if (y_r == VACT_LAST) begin
                        y_nxt_s     = 11'd0;
                        fcnt_nxt_s  = fcnt_r + 8'd1;
                        state_nxt_s = ST_VBLANK;
                    end else begin
                        y_nxt_s     = y_r + 11'd1;
                        state_nxt_s = ST_ACTIVE_PIX;
                    end
                end else begin
                    x_nxt_s = x_r + 11'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                x_nxt_s     = 11'd0;
                y_nxt_s     = 11'd0;
            end
        endcase
    end

    d8m_pattern_pixel u_pixel (
        .x        (x_nxt_s),
        .y        (y_nxt_s),
        .sel      (sel_nxt_s),
        .bar      (bar_nxt_s),
        .flat_cnt (flat_nxt_s),
        .d        (pix_s)
    );

    // Output values for the state being entered, so D/HS/VS align on one edge.
    always_comb begin
        hs_nxt_s = (state_nxt_s == ST_ACTIVE_PIX);
        vs_nxt_s = (state_nxt_s == ST_ACTIVE_PIX) || (state_nxt_s == ST_ACTIVE_BLK);
        if (hs_nxt_s) d_nxt_s = pix_s;
        else          d_nxt_s = 10'h000;
    end

    // FSM state and raster counters.
    always_ff @(posedge MIPI_PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r  <= ST_IDLE;
            x_r      <= 11'd0;
            y_r      <= 11'd0;
            bar_r    <= 3'd0;
            bar_px_r <= 7'd0;
            sel_r    <= 2'd0;
            fcnt_r   <= 8'd0;
            flat_r   <= 8'd0;
        end else begin
            state_r  <= state_nxt_s;
            x_r      <= x_nxt_s;
            y_r      <= y_nxt_s;
            bar_r    <= bar_nxt_s;
            bar_px_r <= bar_px_nxt_s;
            sel_r    <= sel_nxt_s;
            fcnt_r   <= fcnt_nxt_s;
            flat_r   <= flat_nxt_s;
        end
    end

    // Registered stream outputs.
    always_ff @(posedge MIPI_PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            d_r  <= 10'h000;
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            fs_r <= 1'b0;
        end else begin
            d_r  <= d_nxt_s;
            hs_r <= hs_nxt_s;
            vs_r <= vs_nxt_s;
            fs_r <= fs_nxt_s;
        end
    end

    assign MIPI_PIXEL_D  = d_r;
    assign MIPI_PIXEL_HS = hs_r;
    assign MIPI_PIXEL_VS = vs_r;
    assign frame_start   = fs_r;
    assign frame_cnt     = fcnt_r;

endmodule

// File: tb/tb_d8m_pattern_source.sv
// Directed bench: a wide instance (full 640-pixel lines, short frames) for
// pattern content and raster timing, a tiny instance for the 257-frame wrap.
module tb_d8m_pattern_source;

    localparam int B_HA = 640;
    localparam int B_HB = 8;
    localparam int B_VB = 2;
    localparam int B_VA = 33;
    localparam int B_LINE = B_HA + B_HB;
    localparam int S_HA = 4;
    localparam int S_HB = 2;
    localparam int S_VB = 1;
    localparam int S_VA = 2;
    localparam int S_LINE = S_HA + S_HB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       b_en = 1'b0, s_en = 1'b0;
    logic [1:0] b_sel = 2'd0, s_sel = 2'd0;
    logic [9:0] b_d, s_d;
    logic       b_hs, b_vs, b_fs, s_hs, s_vs, s_fs;
    logic [7:0] b_fc, s_fc;

    int n_cmp = 0;
    int n_err = 0;
    int n, pos, bad, run, pulses, badrun, badramp, fs_cnt, vs_cyc, fc_bad;
    logic prev_hs;
    logic [9:0] exp_d;

    always #5 clk = ~clk;

    d8m_pattern_source #(.H_ACTIVE(B_HA), .H_BLANK(B_HB), .V_BLANK(B_VB),
                         .V_ACTIVE(B_VA), .BAR_W(80)) u_big (
        .MIPI_PIXEL_CLK (clk),
        .RESET_N        (rst_n),
        .enable         (b_en),
        .pattern_sel    (b_sel),
        .MIPI_PIXEL_D   (b_d),
        .MIPI_PIXEL_HS  (b_hs),
        .MIPI_PIXEL_VS  (b_vs),
        .frame_start    (b_fs),
        .frame_cnt      (b_fc)
    );

    d8m_pattern_source #(.H_ACTIVE(S_HA), .H_BLANK(S_HB), .V_BLANK(S_VB),
                         .V_ACTIVE(S_VA), .BAR_W(80)) u_small (
        .MIPI_PIXEL_CLK (clk),
        .RESET_N        (rst_n),
        .enable         (s_en),
        .pattern_sel    (s_sel),
        .MIPI_PIXEL_D   (s_d),
        .MIPI_PIXEL_HS  (s_hs),
        .MIPI_PIXEL_VS  (s_vs),
        .frame_start    (s_fs),
        .frame_cnt      (s_fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic seek(input int yy, input int xx);
        int tgt;
        tgt = yy * B_LINE + xx;
        while (pos < tgt) begin
            tick();
            pos++;
        end
    endtask

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_big", {b_vs, b_hs, b_d, b_fs, b_fc}, 32'd0);
        check("rst_small", {s_vs, s_hs, s_d, s_fs, s_fc}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        b_en = 1'b1;
        b_sel = 2'd0;

        // startup: VS rises after a full VBLANK
        n = 0;
        while (!b_vs && n < 2000) begin tick(); n++; end
        check("startup_latency", n, B_VB * B_LINE + 1);
        check("f1_frame_start", b_fs, 1'b1);

        // ramp on line 0, then horizontal blank
        for (int i = 0; i < B_HA; i++) begin
            check("ramp_line0", {b_vs, b_hs, b_d}, {1'b1, 1'b1, i[9:0]});
            tick();
        end
        for (int i = 0; i < B_HB; i++) begin
            check("hblank_line0", {b_vs, b_hs, b_d}, {1'b1, 1'b0, 10'h000});
            tick();
        end

        // rest of frame 1: line structure, ramp content, single frame_start
        run = 0; pulses = 1; badrun = 0; badramp = 0; fs_cnt = 0;
        vs_cyc = B_LINE; fc_bad = 0; prev_hs = 1'b0; n = 0;
        while (b_vs && n < 30000) begin
            if (b_hs) begin
                if (!prev_hs) pulses++;
                if (b_d !== run[9:0]) badramp++;
                run++;
            end else begin
                if (prev_hs && run != B_HA) badrun++;
                run = 0;
            end
            if (b_fs) fs_cnt++;
            if (b_fc != 8'd0) fc_bad++;
            if (n == 5000) b_sel = 2'd1;
            prev_hs = b_hs;
            vs_cyc++;
            n++;
            tick();
        end
        check("f1_hs_pulses", pulses, B_VA);
        check("f1_bad_runs", badrun, 0);
        check("f1_ramp_errs", badramp, 0);
        check("f1_extra_fs", fs_cnt, 0);
        check("f1_vs_cycles", vs_cyc, B_VA * B_LINE);
        check("f1_cnt_during", fc_bad, 0);
        check("f1_cnt_after", b_fc, 8'd1);

        // frame 2: colour bars (sel changed mid-frame must not take effect)
        n = 0;
        while (!b_fs && n < 3000) begin tick(); n++; end
        check("f2_vblank_len", n, B_VB * B_LINE);
        pos = 0;
        b_sel = 2'd2;
        seek(0, 0);   check("bars_y0_x0",   {b_hs, b_d}, {1'b1, 10'h3FF});
        seek(0, 81);  check("bars_y0_x81",  {b_hs, b_d}, {1'b1, 10'h3FF});
        seek(0, 240); check("bars_y0_x240", {b_hs, b_d}, {1'b1, 10'h000});
        seek(0, 561); check("bars_y0_x561", {b_hs, b_d}, {1'b1, 10'h000});
        seek(1, 160); check("bars_y1_x160", {b_hs, b_d}, {1'b1, 10'h3FF});
        seek(1, 161); check("bars_y1_x161", {b_hs, b_d}, {1'b1, 10'h000});

        // frame 3: checkerboard; enable dropped and sel changed mid-frame
        n = 0;
        while (!b_fs && n < 25000) begin tick(); n++; end
        check("f3_start", b_fs, 1'b1);
        pos = 0;
        seek(0, 31);  check("chk_y0_x31",  {b_hs, b_d}, {1'b1, 10'h000});
        seek(0, 32);  check("chk_y0_x32",  {b_hs, b_d}, {1'b1, 10'h3FF});
        seek(1, 32);  check("chk_y1_x32",  {b_hs, b_d}, {1'b1, 10'h3FF});
        b_en = 1'b0;
        b_sel = 2'd0;
        seek(32, 0);  check("chk_y32_x0",  {b_hs, b_d}, {1'b1, 10'h3FF});
        seek(32, 32); check("chk_y32_x32", {b_hs, b_d}, {1'b1, 10'h000});
        seek(32, 64); check("chk_y32_x64", {b_hs, b_d}, {1'b1, 10'h3FF});

        // frame completes, VBLANK completes, then IDLE with all outputs low
        n = 0;
        while (b_vs && n < 2000) begin tick(); n++; end
        check("f3_vs_fall", b_vs, 1'b0);
        bad = 0;
        for (int i = 0; i < B_VB * B_LINE + 6; i++) begin
            if ({b_vs, b_hs, b_d, b_fs} !== 13'd0) bad++;
            tick();
        end
        check("idle_outputs", bad, 0);
        check("idle_frame_cnt", b_fc, 8'd3);

        // re-enable: new pattern (ramp) only after a full VBLANK
        b_en = 1'b1;
        n = 0;
        while (!b_vs && n < 2000) begin tick(); n++; end
        check("restart_latency", n, B_VB * B_LINE + 1);
        check("restart_first", {b_fs, b_hs, b_d}, {1'b1, 1'b1, 10'd0});
        for (int i = 0; i < 7; i++) tick();
        check("restart_ramp", {b_hs, b_d}, {1'b1, 10'd7});

        // small instance: flat pattern over 257 frames, frame_cnt wraps
        s_sel = 2'd3;
        s_en = 1'b1;
        for (int f = 0; f < 257; f++) begin
            n = 0;
            while (!s_fs && n < 40) begin tick(); n++; end
            check("flat_frame_start", s_fs, 1'b1);
            check("flat_cnt_at_start", s_fc, f % 256);
            exp_d = {f[7:0], 2'b00};
            bad = 0;
            n = 0;
            while (s_vs && n < 40) begin
                if (s_hs && s_d !== exp_d) bad++;
                tick();
                n++;
            end
            check("flat_value", bad, 0);
            check("flat_cnt_after", s_fc, (f + 1) % 256);
        end

        // asynchronous reset in the middle of a line
        n = 0;
        while (!s_hs && n < 20) begin tick(); n++; end
        tick();
        check("pre_reset_pixel", {s_vs, s_hs, s_d}, {1'b1, 1'b1, 10'd4});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_small", {s_vs, s_hs, s_d, s_fs, s_fc}, 32'd0);
        check("async_rst_big", {b_vs, b_hs, b_d, b_fs, b_fc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!s_vs && n < 40) begin tick(); n++; end
        check("post_reset_latency", n, S_VB * S_LINE + 1);
        check("post_reset_flat", {s_fs, s_hs, s_d}, {1'b1, 1'b1, 10'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
